mem_arbiter: RTL and testbench



---
 rtl/xcore_pkg.sv | 15 +
 rtl/arb_pick.sv | 34 +++
 rtl/mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xcore_pkg.sv
// Shared core types for the memory arbiter: FSM state and transaction owner.
package xcore_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWNER_IFU = 1'b0,
    OWNER_LSU = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner select between IFU and LSU requests.
// ARB_RR_EN selects round-robin on ties; otherwise LSU has fixed priority.
module arb_pick
  import xcore_pkg::*;
(
  input  logic       ifu_valid_i,
  input  logic       lsu_valid_i,
  input  arb_owner_t last_grant_i,
  output logic       grant_valid_o,
  output arb_owner_t grant_o
);

  assign grant_valid_o = ifu_valid_i | lsu_valid_i;

  always_comb begin
    grant_o = OWNER_IFU;
    if (ifu_valid_i && lsu_valid_i) begin
`ifdef ARB_RR_EN
      // On a tie, hand the port to whoever did not win last time
      grant_o = (last_grant_i == OWNER_LSU) ? OWNER_IFU : OWNER_LSU;
`else
      grant_o = OWNER_LSU;
`endif
    end else if (lsu_valid_i) begin
      grant_o = OWNER_LSU;
    end
  end

`ifndef ARB_RR_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant_i;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported memory between IFU and LSU, one transaction in flight.
// Optional macro ARB_RR_EN: round-robin tie-break instead of fixed LSU priority.
module mem_arbiter
  import xcore_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_resp_valid,
  input  logic                ifu_resp_ready,
  output logic [DATA_W-1:0]   ifu_rdata,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wstrb,
  output logic                lsu_resp_valid,
  input  logic                lsu_resp_ready,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_resp_valid,
  output logic                mem_resp_ready,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int unsigned STRB_W = DATA_W / 8;

  arb_state_t          state_q, state_d;
  arb_owner_t          owner_q, owner_d;
  arb_owner_t          last_grant_q, last_grant_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;

  logic       grant_valid;
  arb_owner_t grant;
  logic       owner_resp_ready;

  arb_pick u_pick (
    .ifu_valid_i   (ifu_req_valid),
    .lsu_valid_i   (lsu_req_valid),
    .last_grant_i  (last_grant_q),
    .grant_valid_o (grant_valid),
    .grant_o       (grant)
  );

  assign owner_resp_ready = (owner_q == OWNER_LSU) ? lsu_resp_ready : ifu_resp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB_IDLE;
      owner_q      <= OWNER_IFU;
      last_grant_q <= OWNER_IFU;
      addr_q       <= '0;
      wen_q        <= 1'b0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wen_q        <= wen_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
    end
  end

  // Next state, payload capture and combinational handshake routing
  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    last_grant_d   = last_grant_q;
    addr_d         = addr_q;
    wen_d          = wen_q;
    wdata_d        = wdata_q;
    wstrb_d        = wstrb_q;
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    ifu_resp_valid = 1'b0;
    lsu_resp_valid = 1'b0;
    ifu_rdata      = '0;
    lsu_rdata      = '0;
    mem_resp_ready = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        // rst_n gating keeps the ready outputs low while reset is held
        if (grant_valid && rst_n) begin
          owner_d = grant;
          state_d = ARB_REQ;
          if (grant == OWNER_LSU) begin
            lsu_req_ready = 1'b1;
            addr_d        = lsu_addr;
            wen_d         = lsu_wen;
            wdata_d       = lsu_wdata;
            wstrb_d       = lsu_wstrb;
          end else begin
            ifu_req_ready = 1'b1;
            addr_d        = ifu_addr;
            wen_d         = 1'b0;
            wdata_d       = '0;
            wstrb_d       = '0;
          end
        end
      end
      ARB_REQ: begin
        if (mem_req_ready) state_d = ARB_RESP;
      end
      ARB_RESP: begin
        mem_resp_ready = owner_resp_ready;
        if (owner_q == OWNER_LSU) begin
          lsu_resp_valid = mem_resp_valid;
          lsu_rdata      = mem_rdata;
        end else begin
          ifu_resp_valid = mem_resp_valid;
          ifu_rdata      = mem_rdata;
        end
        if (mem_resp_valid && owner_resp_ready) begin
          state_d      = ARB_IDLE;
          last_grant_d = owner_q;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign mem_req_valid = (state_q == ARB_REQ);
  assign mem_addr      = addr_q;
  assign mem_wen       = wen_q;
  assign mem_wdata     = wdata_q;
  assign mem_wstrb     = wstrb_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;
`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready;
  logic [AW-1:0] ifu_addr;
  logic [DW-1:0] ifu_rdata;
  logic lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_ready;
  logic [AW-1:0] lsu_addr;
  logic [DW-1:0] lsu_wdata, lsu_rdata;
  logic [SW-1:0] lsu_wstrb;
  logic mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, mem_resp_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [SW-1:0] mem_wstrb;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_rdata(mem_rdata)
  );

  int total = 0;
  int bad   = 0;

  // Transaction-level model: is a transaction held, has memory taken it, who owns it
  bit          m_busy, m_sent, m_owner_lsu, m_last_lsu;
  bit [AW-1:0] m_addr;
  bit          m_wen;
  bit [DW-1:0] m_wdata;
  bit [SW-1:0] m_wstrb;
  bit          e_win_lsu, e_any, e_mrr;
  bit          acc_ifu, acc_lsu;
  bit          ifu_pend, lsu_pend;
  int          dut_lsu_hs = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive valids from pending flags, let logic settle, compare against the model
  task automatic settle();
    bit e_irdy, e_lrdy, e_mrv, e_irv, e_lrv, e_pay;
    bit [DW-1:0] e_ird, e_lrd;
    ifu_req_valid = ifu_pend;
    lsu_req_valid = lsu_pend;
    #1;
    e_irdy = 0; e_lrdy = 0; e_mrv = 0; e_irv = 0; e_lrv = 0; e_mrr = 0;
    e_ird = '0; e_lrd = '0; e_pay = !rst_n; e_any = 0; e_win_lsu = 0;
    if (rst_n) begin
      if (!m_busy) begin
        e_any = ifu_req_valid || lsu_req_valid;
        if (ifu_req_valid && lsu_req_valid) e_win_lsu = RR ? !m_last_lsu : 1'b1;
        else e_win_lsu = lsu_req_valid;
        e_irdy = e_any && !e_win_lsu;
        e_lrdy = e_any && e_win_lsu;
      end else if (!m_sent) begin
        e_mrv = 1; e_pay = 1;
      end else begin
        e_mrr = m_owner_lsu ? lsu_resp_ready : ifu_resp_ready;
        if (m_owner_lsu) begin e_lrv = mem_resp_valid; e_lrd = mem_rdata; end
        else begin e_irv = mem_resp_valid; e_ird = mem_rdata; end
      end
    end
    chk("ifu_req_ready", ifu_req_ready, e_irdy);
    chk("lsu_req_ready", lsu_req_ready, e_lrdy);
    chk("mem_req_valid", mem_req_valid, e_mrv);
    chk("mem_resp_ready", mem_resp_ready, e_mrr);
    chk("ifu_resp_valid", ifu_resp_valid, e_irv);
    chk("lsu_resp_valid", lsu_resp_valid, e_lrv);
    chk("ifu_rdata", ifu_rdata, e_ird);
    chk("lsu_rdata", lsu_rdata, e_lrd);
    if (e_pay) begin
      chk("mem_addr", mem_addr, rst_n ? m_addr : '0);
      chk("mem_wen", mem_wen, rst_n ? m_wen : 1'b0);
      chk("mem_wdata", mem_wdata, rst_n ? m_wdata : '0);
      chk("mem_wstrb", mem_wstrb, rst_n ? m_wstrb : '0);
    end
    if (rst_n && lsu_resp_valid && lsu_resp_ready) dut_lsu_hs++;
  endtask

  // Advance the model by the handshakes of this cycle, then cross the clock edge
  task automatic adv();
    acc_ifu = 0; acc_lsu = 0;
    if (!rst_n) begin
      m_busy = 0; m_sent = 0; m_last_lsu = 0;
    end else if (!m_busy) begin
      if (e_any) begin
        m_busy = 1; m_sent = 0; m_owner_lsu = e_win_lsu;
        if (e_win_lsu) begin
          acc_lsu = 1;
          m_addr = lsu_addr; m_wen = lsu_wen; m_wdata = lsu_wdata; m_wstrb = lsu_wstrb;
        end else begin
          acc_ifu = 1;
          m_addr = ifu_addr; m_wen = 0; m_wdata = '0; m_wstrb = '0;
        end
      end
    end else if (!m_sent) begin
      if (mem_req_ready) m_sent = 1;
    end else if (mem_resp_valid && e_mrr) begin
      m_busy = 0; m_last_lsu = m_owner_lsu;
    end
    @(posedge clk);
    @(negedge clk);
    if (acc_ifu) ifu_pend = 0;
    if (acc_lsu) lsu_pend = 0;
  endtask

  // Serve everything outstanding with a zero-wait memory
  task automatic drain();
    mem_req_ready = 1; mem_resp_valid = 1; ifu_resp_ready = 1; lsu_resp_ready = 1;
    for (int i = 0; i < 60; i++) begin
      settle();
      adv();
      if (!m_busy && !ifu_pend && !lsu_pend) begin
        mem_resp_valid = 0;
        return;
      end
    end
    chk("drain_timeout", 1, 0);
    mem_resp_valid = 0;
  endtask

  int hs0;

  initial begin
    rst_n = 0; ifu_pend = 0; lsu_pend = 0;
    ifu_req_valid = 0; lsu_req_valid = 0; ifu_addr = '0; lsu_addr = '0;
    lsu_wen = 0; lsu_wdata = '0; lsu_wstrb = '0;
    ifu_resp_ready = 0; lsu_resp_ready = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = '0;
    m_busy = 0; m_sent = 0; m_owner_lsu = 0; m_last_lsu = 0;
    m_addr = '0; m_wen = 0; m_wdata = '0; m_wstrb = '0;
    @(negedge clk);
    settle();
    chk("rst_mem_req_valid", mem_req_valid, 0);
    chk("rst_mem_addr", mem_addr, 0);
    adv();
    rst_n = 1;

    // IFU only, zero-wait memory
    ifu_pend = 1; ifu_addr = 32'h8000_0000; mem_req_ready = 1; mem_resp_valid = 0;
    ifu_resp_ready = 1; lsu_resp_ready = 1;
    settle();
    chk("t1_ifu_ready", ifu_req_ready, 1);
    chk("t1_lsu_ready", lsu_req_ready, 0);
    adv();
    settle();
    chk("t1_mem_req_valid", mem_req_valid, 1);
    chk("t1_mem_wen", mem_wen, 0);
    chk("t1_mem_addr", mem_addr, 32'h8000_0000);
    adv();
    mem_resp_valid = 1; mem_rdata = 32'h0000_0413;
    settle();
    chk("t1_ifu_resp_valid", ifu_resp_valid, 1);
    chk("t1_ifu_rdata", ifu_rdata, 32'h0000_0413);
    chk("t1_lsu_resp_valid", lsu_resp_valid, 0);
    adv();
    mem_resp_valid = 0;

    // Tie with last grant IFU: LSU store wins in both modes, IFU 3 cycles later
    lsu_pend = 1; lsu_addr = 32'h8000_0100; lsu_wen = 1; lsu_wdata = 32'hDEAD_BEEF; lsu_wstrb = 4'hF;
    ifu_pend = 1; ifu_addr = 32'h8000_0004;
    settle();
    chk("tie1_lsu_ready", lsu_req_ready, 1);
    chk("tie1_ifu_ready", ifu_req_ready, 0);
    adv();
    settle();
    chk("tie1_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("tie1_mem_wen", mem_wen, 1);
    chk("tie1_mem_wstrb", mem_wstrb, 4'hF);
    adv();
    mem_resp_valid = 1;
    settle();
    chk("tie1_lsu_resp_valid", lsu_resp_valid, 1);
    adv();
    mem_resp_valid = 0;
    settle();
    chk("tie1_ifu_ready_late", ifu_req_ready, 1);
    adv();
    drain();

    // LSU alone so last grant is LSU, then tie
    lsu_pend = 1; lsu_addr = 32'h8000_0200; lsu_wen = 0;
    drain();
    lsu_pend = 1; ifu_pend = 1; ifu_addr = 32'h8000_0008; mem_resp_valid = 0;
    settle();
    chk("tie2_ifu_ready", ifu_req_ready, RR);
    chk("tie2_lsu_ready", lsu_req_ready, !RR);
    adv();
    drain();

    // Memory stalls and LSU back-pressure
    lsu_pend = 1; lsu_addr = 32'h8000_0300; lsu_wen = 0; mem_req_ready = 0; mem_resp_valid = 0;
    settle();
    adv();
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("stall_mem_req_valid", mem_req_valid, 1);
      chk("stall_mem_addr", mem_addr, 32'h8000_0300);
      adv();
    end
    mem_req_ready = 1;
    settle();
    adv();
    mem_resp_valid = 1; lsu_resp_ready = 0; mem_rdata = 32'hCAFE_0001; hs0 = dut_lsu_hs;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("bp_lsu_resp_valid", lsu_resp_valid, 1);
      chk("bp_mem_resp_ready", mem_resp_ready, 0);
      chk("bp_mem_addr", mem_addr, 32'h8000_0300);
      adv();
    end
    lsu_resp_ready = 1;
    settle();
    chk("bp_mem_resp_ready_go", mem_resp_ready, 1);
    adv();
    settle();
    chk("bp_after_lsu_resp_valid", lsu_resp_valid, 0);
    chk("bp_one_handshake", dut_lsu_hs - hs0, 1);
    adv();
    mem_resp_valid = 0;

    // Reset asserted while in RESP
    lsu_pend = 1; lsu_addr = 32'h8000_0400; mem_req_ready = 1;
    settle(); adv();
    settle(); adv();
    mem_resp_valid = 1; lsu_resp_ready = 0;
    settle();
    chk("rr_lsu_resp_valid", lsu_resp_valid, 1);
    adv();
    rst_n = 0;
    settle();
    chk("rr_lsu_resp_valid_rst", lsu_resp_valid, 0);
    chk("rr_mem_resp_ready_rst", mem_resp_ready, 0);
    chk("rr_mem_addr_rst", mem_addr, 0);
    adv();
    rst_n = 1; mem_resp_valid = 0; lsu_resp_ready = 1;
    ifu_pend = 1; ifu_addr = 32'h8000_0010;
    settle();
    chk("rr_ifu_ready_after", ifu_req_ready, 1);
    adv();
    drain();

    // Stray memory response in IDLE
    mem_resp_valid = 1; mem_rdata = 32'h1234_5678;
    settle();
    chk("stray_ifu_resp_valid", ifu_resp_valid, 0);
    chk("stray_lsu_resp_valid", lsu_resp_valid, 0);
    chk("stray_mem_resp_ready", mem_resp_ready, 0);
    adv();
    mem_resp_valid = 0;

    // Randomized traffic; requesters hold valid and payload until accepted
    for (int c = 0; c < 3000; c++) begin
      if (!ifu_pend && $urandom_range(1, 0) == 1) begin
        ifu_pend = 1; ifu_addr = $urandom;
      end
      if (!lsu_pend && $urandom_range(1, 0) == 1) begin
        lsu_pend = 1; lsu_addr = $urandom; lsu_wen = 1'($urandom_range(1, 0));
        lsu_wdata = $urandom; lsu_wstrb = 4'($urandom_range(15, 0));
      end
      mem_req_ready  = 1'($urandom_range(1, 0));
      mem_resp_valid = 1'($urandom_range(1, 0));
      mem_rdata      = $urandom;
      ifu_resp_ready = ($urandom_range(3, 0) != 0);
      lsu_resp_ready = ($urandom_range(3, 0) != 0);
      settle();
      adv();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
